// File: rtl/pc_stack.sv
// Program counter with increment, load, subroutine call and return.
// Return addresses live in a small register-array LIFO whose fill level is exposed as sp.
module pc_stack #(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic                     load,
  input  logic                     inc,
  input  logic                     call,
  input  logic                     ret,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     empty,
  output logic                     full,
  output logic                     wrap,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] ret_addr;
  logic [SPW-1:0]   sp_dec;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;
  logic             push;
  logic             out_max;

  assign empty    = (sp == '0);
  assign full     = (sp == SPW'(DEPTH));
  assign sp_dec   = sp - 1'b1;
  assign push_idx = sp[AW-1:0];
  assign top_idx  = sp_dec[AW-1:0];
  // Return address always wraps, even when the increment path saturates.
  assign ret_addr = out + 1'b1;
  assign out_max  = (out == {WIDTH{1'b1}});
  assign push     = !reset && !load && call && !full;

  // Entries carry no reset; only sp decides which ones are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[push_idx] <= ret_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= RESET_VALUE;
      sp        <= '0;
      wrap      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        out <= in;
      end else if (call) begin
        if (!full) begin
          sp  <= sp + 1'b1;
          out <= in;
        end else begin
          overflow <= 1'b1;
        end
      end else if (ret) begin
        if (!empty) begin
          sp  <= sp_dec;
          out <= stack[top_idx];
        end else begin
          underflow <= 1'b1;
        end
      end else if (inc) begin
        if (out_max) begin
          wrap <= 1'b1;
          out  <= SATURATE ? {WIDTH{1'b1}} : '0;
        end else begin
          out <= out + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: a wrapping DEPTH=8 instance and a saturating DEPTH=4 instance.
// Drivers queue expected state; a monitor compares the registered outputs one cycle later.
module tb_pc_stack;

  localparam logic [4:0] RST  = 5'b10000;
  localparam logic [4:0] LD   = 5'b01000;
  localparam logic [4:0] CL   = 5'b00100;
  localparam logic [4:0] RT   = 5'b00010;
  localparam logic [4:0] IN   = 5'b00001;
  localparam logic [4:0] HOLD = 5'b00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0 = 1'b0, load0 = 1'b0, inc0 = 1'b0, call0 = 1'b0, ret0 = 1'b0;
  logic [15:0] in0 = '0;
  logic [15:0] out0;
  logic [3:0]  sp0;
  logic        empty0, full0, wrap0, ovf0, unf0;

  logic        reset1 = 1'b0, load1 = 1'b0, inc1 = 1'b0, call1 = 1'b0, ret1 = 1'b0;
  logic [15:0] in1 = '0;
  logic [15:0] out1;
  logic [2:0]  sp1;
  logic        empty1, full1, wrap1, ovf1, unf1;

  pc_stack #(.WIDTH(16), .DEPTH(8), .RESET_VALUE(16'h0000), .SATURATE(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .in(in0), .load(load0), .inc(inc0), .call(call0), .ret(ret0),
    .out(out0), .sp(sp0), .empty(empty0), .full(full0), .wrap(wrap0),
    .overflow(ovf0), .underflow(unf0)
  );

  pc_stack #(.WIDTH(16), .DEPTH(4), .RESET_VALUE(16'h1234), .SATURATE(1'b1)) dut1 (
    .clk(clk), .reset(reset1), .in(in1), .load(load1), .inc(inc1), .call(call1), .ret(ret1),
    .out(out1), .sp(sp1), .empty(empty1), .full(full1), .wrap(wrap1),
    .overflow(ovf1), .underflow(unf1)
  );

  // Entry layout: {sel, out[15:0], sp[3:0], wrap, overflow, underflow}
  logic [23:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          issued = 1'b0;

  task automatic op(input string name, input bit sel, input logic [4:0] ctl,
                    input logic [15:0] d, input logic [15:0] e_out, input logic [3:0] e_sp,
                    input bit e_w, input bit e_o, input bit e_u);
    @(negedge clk);
    {reset0, load0, call0, ret0, inc0} = sel ? 5'b0 : ctl;
    {reset1, load1, call1, ret1, inc1} = sel ? ctl : 5'b0;
    in0 = d;
    in1 = d;
    issued = 1'b1;
    exp_q.push_back({sel, e_out, e_sp, e_w, e_o, e_u});
    name_q.push_back(name);
  endtask

  task automatic idle();
    @(negedge clk);
    {reset0, load0, call0, ret0, inc0} = 5'b0;
    {reset1, load1, call1, ret1, inc1} = 5'b0;
    issued = 1'b0;
  endtask

  // Monitor: an op driven before a rising edge is checked at the following falling edge.
  initial begin : monitor
    bit          was;
    logic [23:0] e;
    logic [23:0] act;
    logic [1:0]  act_ef;
    logic [1:0]  exp_ef;
    string       nm;
    forever begin
      @(posedge clk);
      was = issued;
      @(negedge clk);
      if (was) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL monitor: output cycle with empty expected queue");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (e[23]) begin
            act    = {1'b1, out1, {1'b0, sp1}, wrap1, ovf1, unf1};
            act_ef = {empty1, full1};
            exp_ef = {e[6:3] == 4'd0, e[6:3] == 4'd4};
          end else begin
            act    = {1'b0, out0, sp0, wrap0, ovf0, unf0};
            act_ef = {empty0, full0};
            exp_ef = {e[6:3] == 4'd0, e[6:3] == 4'd8};
          end
          if (act !== e || act_ef !== exp_ef) begin
            bad++;
            $display("FAIL %s: got out=%h sp=%0d wrap=%b ovf=%b unf=%b empty,full=%b want out=%h sp=%0d wrap=%b ovf=%b unf=%b empty,full=%b",
                     nm, act[22:7], act[6:3], act[2], act[1], act[0], act_ef,
                     e[22:7], e[6:3], e[2], e[1], e[0], exp_ef);
          end
        end
      end
    end
  end

  initial begin : driver
    idle();
    // Wrapping instance: reset, increment, wrap
    op("reset", 0, RST, 16'h0, 16'h0000, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) op("inc", 0, IN, 16'h0, 16'(i), 4'd0, 0, 0, 0);
    op("ld_7ffe",   0, LD,   16'h7FFE, 16'h7FFE, 4'd0, 0, 0, 0);
    op("inc_7fff",  0, IN,   16'h0,    16'h7FFF, 4'd0, 0, 0, 0);
    op("inc_8000",  0, IN,   16'h0,    16'h8000, 4'd0, 0, 0, 0);
    op("ld_ffff",   0, LD,   16'hFFFF, 16'hFFFF, 4'd0, 0, 0, 0);
    op("inc_wrap",  0, IN,   16'h0,    16'h0000, 4'd0, 1, 0, 0);
    op("wrap_drop", 0, HOLD, 16'h0,    16'h0000, 4'd0, 0, 0, 0);
    // Single call / return
    op("ld_0010",   0, LD,   16'h0010, 16'h0010, 4'd0, 0, 0, 0);
    op("call_0100", 0, CL,   16'h0100, 16'h0100, 4'd1, 0, 0, 0);
    op("sub_inc1",  0, IN,   16'h0,    16'h0101, 4'd1, 0, 0, 0);
    op("sub_inc2",  0, IN,   16'h0,    16'h0102, 4'd1, 0, 0, 0);
    op("ret_0011",  0, RT,   16'h0,    16'h0011, 4'd0, 0, 0, 0);
    // Nested calls from distinct addresses A00, A10, ... A70
    for (int k = 0; k < 8; k++) begin
      op("nest_ld",   0, LD, 16'hA00 + 16'(k * 16), 16'hA00 + 16'(k * 16), 4'(k),     0, 0, 0);
      op("nest_call", 0, CL, 16'h100 + 16'(k),      16'h100 + 16'(k),      4'(k + 1), 0, 0, 0);
    end
    op("call_full", 0, CL, 16'h0200, 16'h0107, 4'd8, 0, 1, 0);
    for (int j = 0; j < 8; j++)
      op("ret_lifo", 0, RT, 16'h0, 16'hA01 + 16'((7 - j) * 16), 4'(7 - j), 0, 1, 0);
    op("ret_empty", 0, RT, 16'h0, 16'h0A01, 4'd0, 0, 1, 1);
    // Priority resolution
    op("call_300",  0, CL,           16'h0300, 16'h0300, 4'd1, 0, 1, 1);
    op("prio_load", 0, LD | CL | IN, 16'h0042, 16'h0042, 4'd1, 0, 1, 1);
    op("prio_ret",  0, RT | IN,      16'h0,    16'h0A02, 4'd0, 0, 1, 1);
    op("call_500",  0, CL,           16'h0500, 16'h0500, 4'd1, 0, 1, 1);
    op("ret_b2b",   0, RT,           16'h0,    16'h0A03, 4'd0, 0, 1, 1);
    op("prio_call", 0, CL | RT,      16'h0600, 16'h0600, 4'd1, 0, 1, 1);
    op("call_601",  0, CL,           16'h0601, 16'h0601, 4'd2, 0, 1, 1);
    op("call_602",  0, CL,           16'h0602, 16'h0602, 4'd3, 0, 1, 1);
    op("rst_call",  0, RST | CL,     16'h0700, 16'h0000, 4'd0, 0, 0, 0);
    op("post_rst",  0, HOLD,         16'h0,    16'h0000, 4'd0, 0, 0, 0);
    // Saturating instance
    op("sat_reset", 1, RST,  16'h0,    16'h1234, 4'd0, 0, 0, 0);
    op("sat_ld",    1, LD,   16'hFFFF, 16'hFFFF, 4'd0, 0, 0, 0);
    op("sat_inc1",  1, IN,   16'h0,    16'hFFFF, 4'd0, 1, 0, 0);
    op("sat_inc2",  1, IN,   16'h0,    16'hFFFF, 4'd0, 1, 0, 0);
    op("sat_hold",  1, HOLD, 16'h0,    16'hFFFF, 4'd0, 0, 0, 0);
    op("sat_call",  1, CL,   16'h0010, 16'h0010, 4'd1, 0, 0, 0);
    op("sat_ret",   1, RT,   16'h0,    16'h0000, 4'd0, 0, 0, 0);
    idle();
    idle();
    idle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
